// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and default widths for the convolution coprocessor tap sequencer.
package convolution_coprocessor_pkg;
  localparam int ADDR_WIDTH_DEF = 5;

  // Sizes go up to 2^ADDR_WIDTH inclusive, so they need one more bit than an address.
  function automatic int size_width(input int aw);
    return aw + 1;
  endfunction

  localparam int SIZE_WIDTH_DEF = size_width(ADDR_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/convolution_coprocessor_range_calc.sv
// Valid tap range for output n: kmin = max(0, n-N+1), kmax = min(n, M-1).
module convolution_coprocessor_range_calc #(
  parameter int AW = 5,
  parameter int NW = AW + 1,
  parameter int SW = AW + 1
) (
  input  logic [NW-1:0] n_i,
  input  logic [SW-1:0] m_i,
  input  logic [SW-1:0] h_i,
  output logic [AW-1:0] kmin_o,
  output logic [AW-1:0] kmax_o
);
  // One spare bit over the widest operand keeps n-N+1 from wrapping.
  localparam int IW = ((NW > SW) ? NW : SW) + 1;
  localparam logic signed [IW-1:0] ONE = 1;

  logic signed [IW-1:0] n_s, m_s, h_s, lo, m1;

  always_comb begin
    n_s    = IW'(n_i);
    m_s    = IW'(m_i);
    h_s    = IW'(h_i);
    lo     = n_s - h_s + ONE;
    m1     = m_s - ONE;
    kmin_o = lo[IW-1] ? '0 : lo[AW-1:0];
    kmax_o = (n_s < m1) ? n_s[AW-1:0] : m1[AW-1:0];
  end
endmodule

// File: rtl/convolution_coprocessor_index_gen.sv
// Walks every output n of a length-M by length-N convolution and streams the
// valid (k, n-k) tap pairs to the MAC datapath over valid/ready.
module convolution_coprocessor_index_gen
  import convolution_coprocessor_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [SIZE_WIDTH-1:0] size_x_i,
  input  logic [SIZE_WIDTH-1:0] size_h_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  tap_valid_o,
  input  logic                  tap_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_x_o,
  output logic [ADDR_WIDTH-1:0] addr_h_o,
  output logic [ADDR_WIDTH:0]   addr_y_o,
  output logic                  first_tap_o,
  output logic                  last_tap_o
);
  localparam int NW = ADDR_WIDTH + 1;
  localparam logic [SIZE_WIDTH-1:0] MAX_LEN = SIZE_WIDTH'(1 << ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [SIZE_WIDTH-1:0] m_q, m_d, h_q, h_d;
  logic [NW-1:0]         n_q, n_d, n_la;
  logic [ADDR_WIDTH-1:0] k_q, k_d, kmin_q, kmin_d, kmax_q, kmax_d;
  logic [ADDR_WIDTH-1:0] kmin_nxt, kmax_nxt;
  logic                  err_q, err_d;
  logic [SIZE_WIDTH:0]   n_end;
  logic                  n_more;

  // Lookahead on the next output so an n step loads k/kmin/kmax in one cycle.
  assign n_la = (state_q == ST_SETUP) ? '0 : n_q + NW'(1);

  convolution_coprocessor_range_calc #(
    .AW(ADDR_WIDTH),
    .NW(NW),
    .SW(SIZE_WIDTH)
  ) u_range (
    .n_i   (n_la),
    .m_i   (m_q),
    .h_i   (h_q),
    .kmin_o(kmin_nxt),
    .kmax_o(kmax_nxt)
  );

  assign n_end  = {1'b0, m_q} + {1'b0, h_q} - (SIZE_WIDTH + 1)'(2);
  assign n_more = (SIZE_WIDTH + 1)'(n_q) < n_end;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    h_d     = h_q;
    n_d     = n_q;
    k_d     = k_q;
    kmin_d  = kmin_q;
    kmax_d  = kmax_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          m_d = size_x_i;
          h_d = size_h_i;
          if (size_x_i == '0 || size_h_i == '0 || size_x_i > MAX_LEN || size_h_i > MAX_LEN)
            err_d = 1'b1;
          else
            state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        n_d     = '0;
        k_d     = kmin_nxt;
        kmin_d  = kmin_nxt;
        kmax_d  = kmax_nxt;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (tap_ready_i) begin
          if (k_q < kmax_q) begin
            k_d = k_q + ADDR_WIDTH'(1);
          end else if (n_more) begin
            n_d    = n_la;
            k_d    = kmin_nxt;
            kmin_d = kmin_nxt;
            kmax_d = kmax_nxt;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      h_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      kmin_q  <= '0;
      kmax_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      h_q     <= h_d;
      n_q     <= n_d;
      k_q     <= k_d;
      kmin_q  <= kmin_d;
      kmax_q  <= kmax_d;
      err_q   <= err_d;
    end
  end

  // j < N <= 2^ADDR_WIDTH, so the low bits of n-k are exact.
  assign tap_valid_o = (state_q == ST_RUN);
  assign busy_o      = (state_q == ST_SETUP) || (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;
  assign addr_x_o    = k_q;
  assign addr_h_o    = n_q[ADDR_WIDTH-1:0] - k_q;
  assign addr_y_o    = n_q;
  assign first_tap_o = tap_valid_o && (k_q == kmin_q);
  assign last_tap_o  = tap_valid_o && (k_q == kmax_q);
endmodule

// File: tb/tb_convolution_coprocessor_index_gen.sv
// Directed bench: tap stream checked every valid cycle against a loop-based
// enumeration of all (k, n-k) pairs, plus literal sequences and latencies.
module tb_convolution_coprocessor_index_gen;
  localparam int AW = 5;
  localparam int SW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] size_x = '0, size_h = '0;
  logic          tap_ready = 1'b1;
  logic          busy, done, err, tap_valid, first_tap, last_tap;
  logic [AW-1:0] addr_x, addr_h;
  logic [AW:0]   addr_y;

  convolution_coprocessor_index_gen #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .size_x_i(size_x), .size_h_i(size_h),
    .busy_o(busy), .done_o(done), .err_o(err), .tap_valid_o(tap_valid),
    .tap_ready_i(tap_ready), .addr_x_o(addr_x), .addr_h_o(addr_h), .addr_y_o(addr_y),
    .first_tap_o(first_tap), .last_tap_o(last_tap)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int h; int y; bit f; bit l;} tap_t;
  tap_t exp_q[$];
  tap_t cap[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   rmode = 0;
  bit   in_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
  initial forever begin
    @(posedge clk); #1;
    tap_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Enumerate every valid pair; first/last are the smallest/largest valid k per n.
  task automatic build_model(input int m, input int h);
    exp_q.delete();
    for (int n = 0; n <= m + h - 2; n++) begin
      int kf = -1, kl = -1;
      for (int k = 0; k < m; k++)
        if (n - k >= 0 && n - k < h) begin
          if (kf < 0) kf = k;
          kl = k;
        end
      for (int k = kf; k <= kl; k++) begin
        tap_t t;
        t.x = k; t.h = n - k; t.y = n; t.f = (k == kf); t.l = (k == kl);
        exp_q.push_back(t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) in_run = 0;
    else begin
      if (tap_valid) begin
        if (exp_q.size() == 0) chk("unexpected_tap", 1, 0);
        else begin
          tap_t e, a;
          e = exp_q[0];
          a.x = int'(addr_x); a.h = int'(addr_h); a.y = int'(addr_y);
          a.f = first_tap; a.l = last_tap;
          chk("tap_x", a.x, e.x);
          chk("tap_h", a.h, e.h);
          chk("tap_y", a.y, e.y);
          chk("tap_first", int'(a.f), int'(e.f));
          chk("tap_last", int'(a.l), int'(e.l));
          if (tap_ready) begin
            cap.push_back(a);
            void'(exp_q.pop_front());
          end
        end
        in_run = 1;
      end else if (in_run && exp_q.size() != 0) chk("bubble", 0, 1);
      if (done) in_run = 0;
    end
  end

  task automatic do_start(input int m, input int h, output int t0);
    cap.delete();
    build_model(m, h);
    @(posedge clk); #1;
    start = 1'b1; size_x = SW'(m); size_h = SW'(h); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; size_x = SW'($urandom); size_h = SW'($urandom);
  endtask

  task automatic run(input int m, input int h, input bit chk_lat);
    int t0, tdone;
    bit seen;
    do_start(m, h, t0);
    chk("busy_setup", int'(busy), 1);
    chk("valid_setup", int'(tap_valid), 0);
    seen = 0;
    tdone = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; tdone = cyc; end
    end
    chk("done_seen", int'(seen), 1);
    if (chk_lat) chk("done_latency", tdone - t0, 2 + m * h);
    chk("handshakes", cap.size(), m * h);
    chk("model_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  task automatic check_lit32();
    int lx[6] = '{0, 0, 1, 1, 2, 2};
    int lh[6] = '{0, 1, 0, 1, 0, 1};
    int ly[6] = '{0, 1, 1, 2, 2, 3};
    int lf[6] = '{1, 1, 0, 1, 0, 1};
    int ll[6] = '{1, 0, 1, 0, 1, 1};
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      chk($sformatf("lit%0d_x", i), cap[i].x, lx[i]);
      chk($sformatf("lit%0d_h", i), cap[i].h, lh[i]);
      chk($sformatf("lit%0d_y", i), cap[i].y, ly[i]);
      chk($sformatf("lit%0d_f", i), int'(cap[i].f), lf[i]);
      chk($sformatf("lit%0d_l", i), int'(cap[i].l), ll[i]);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_outs"}, int'({busy, done, err, tap_valid, first_tap, last_tap}), 0);
    chk({nm, "_addr"}, int'({addr_x, addr_h, addr_y}), 0);
  endtask

  task automatic err_run(input int m, input int h);
    int t0;
    do_start(m, h, t0);
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("err_clear", int'(err), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("err_no_valid", int'(tap_valid | busy), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("post_reset");

    rmode = 0;
    run(3, 2, 1);
    check_lit32();

    rmode = 1;
    run(3, 2, 0);
    check_lit32();
    rmode = 0;

    run(1, 1, 1);
    if (cap.size() == 1) begin
      chk("single_f", int'(cap[0].f), 1);
      chk("single_l", int'(cap[0].l), 1);
      chk("single_y", cap[0].y, 0);
    end

    err_run(0, 5);
    err_run(4, 33);

    run(32, 32, 1);
    if (cap.size() > 0) chk("final_y", cap[cap.size() - 1].y, 62);

    run(5, 3, 1);

    // Reset in the middle of a run, then a clean restart.
    begin
      int t0;
      do_start(3, 2, t0);
      for (int i = 0; i < 100 && cap.size() < 3; i++) @(negedge clk);
      chk("mid_reached", cap.size(), 3);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_idle_zero("async_reset");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("no_done_after_rst", int'(done | tap_valid), 0);
      end
    end
    run(3, 2, 1);
    check_lit32();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/convolution_coprocessor_index_gen.md
# convolution_coprocessor_index_gen

Parametrised address/tap sequencer for the convolution coprocessor; it replaces the ad-hoc combinational index-validity logic (index ≥ 0, index < size) with a sequential generator. Given input lengths M (x) and N (h), it walks every output sample n = 0..M+N-2 and emits only the valid (k, n−k) tap pairs over a valid/ready stream. It sits between the coprocessor control registers and the MAC datapath, which consumes the tap stream and accumulates y[n].

## Interface
- ADDR_WIDTH, 5, address width of the x and h memories (max length 2^ADDR_WIDTH)
- SIZE_WIDTH, ADDR_WIDTH+1, width of the size inputs
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  start request, sampled only in IDLE
- size_x_i  input  SIZE_WIDTH  M, length of x, sampled with start_i
- size_h_i  input  SIZE_WIDTH  N, length of h, sampled with start_i
- busy_o  output  1  high in SETUP and RUN
- done_o  output  1  one-cycle pulse after the final tap handshake
- err_o  output  1  one-cycle pulse on rejected sizes
- tap_valid_o  output  1  tap outputs hold a valid tap
- tap_ready_i  input  1  consumer accepts tap
- addr_x_o  output  ADDR_WIDTH  k
- addr_h_o  output  ADDR_WIDTH  j = n − k
- addr_y_o  output  ADDR_WIDTH+1  n
- first_tap_o  output  1  tap is first of output n (MAC clears accumulator)
- last_tap_o  output  1  tap is last of output n (MAC writes y[n])

## Operation
- FSM states: IDLE, SETUP, RUN, DONE.
- IDLE: start_i=1 latches M, N. If M=0, N=0, M>2^ADDR_WIDTH or N>2^ADDR_WIDTH, pulse err_o next cycle and stay IDLE; otherwise go to SETUP.
- SETUP (1 cycle): n←0, k←kmin(0)=0; compute kmax. Go to RUN.
- RUN: tap_valid_o=1. Tap outputs are registered and stable while valid & !ready. On handshake (valid & ready):
  - if k<kmax(n): k←k+1;
  - else if n<M+N−2: n←n+1, k←kmin(n+1);
  - else go to DONE.
- kmin(n)=max(0, n−N+1), kmax(n)=min(n, M−1); computed with SIZE_WIDTH+1-bit signed intermediates, no wrap.
- first_tap_o = (k==kmin(n)); last_tap_o = (k==kmax(n)); both high for single-tap outputs.
- DONE (1 cycle): done_o=1, tap_valid_o=0, then IDLE.
- start_i outside IDLE is ignored; size inputs are ignored outside the start cycle.
- Total handshakes per run = M·N exactly; no bubbles and no invalid taps are emitted.

## Timing
- Reset values: all outputs 0, state IDLE, n=k=0.
- rst_i asserted mid-run: immediately IDLE, tap_valid_o drops asynchronously, no done_o; the consumer discards its partial accumulator.
- start_i at cycle t → busy_o and SETUP at t+1 → first tap_valid_o at t+2.
- Throughput: one tap per cycle with tap_ready_i held high; run length M·N+2 cycles from start to done_o (done_o at t+2+M·N).
- err_o is asserted at t+1; busy_o stays 0.
- tap_ready_i low: all tap outputs held; no counter advances.

## Structure
- convolution_coprocessor_pkg: state enum type, default ADDR_WIDTH, SIZE_WIDTH derivation.
- Sub-module convolution_coprocessor_range_calc: combinational kmin/kmax from n, M, N; instantiated once for next-n lookahead.
- Main module: FSM, n/k counters, output registers.

## Test plan
- M=3, N=2, ready high → (x,h,y) sequence (0,0,0)F L; (0,1,1)F; (1,0,1)L; (1,1,2)F; (2,0,2)L; (2,1,3)F L; done_o at start+8.
- Same run, tap_ready_i toggled 1,0,0,1… → identical sequence, outputs stable during stalls, 6 handshakes total.
- M=1, N=1 → single tap (0,0,0) with first and last high, done_o at start+3.
- M=0 or N=2^ADDR_WIDTH+1 → err_o pulse at start+1, busy_o=0, no tap_valid_o.
- M=N=2^ADDR_WIDTH, ready high → 2^(2·ADDR_WIDTH) taps, final addr_y_o = 2^(ADDR_WIDTH+1)−2, no address wrap.
- rst_i pulse after the 3rd tap of the M=3, N=2 run → outputs 0 at once, no done_o; new start_i runs cleanly from n=0.
